// File: rtl/bv_lookup_pkg.sv
// Shared constants, FSM state type and group-select helper for the BV lookup datapath.
package bv_lookup_pkg;
  localparam int RULE_NUM = 32;
  localparam int LANE     = 8;
  localparam int PRIOR_W  = 8;
  localparam int IDX_W    = 8;
  localparam int GRP_NUM  = RULE_NUM / LANE;
  localparam int GRP_W    = $clog2(GRP_NUM);
  localparam int LANE_W   = $clog2(LANE);
  localparam int ADDR_W   = $clog2(RULE_NUM);

  typedef enum logic {IDLE, SCAN} state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [GRP_W-1:0] lowest_grp(input logic [GRP_NUM-1:0] mask);
    lowest_grp = '0;
    for (int g = GRP_NUM - 1; g >= 0; g--) begin
      if (mask[g]) lowest_grp = GRP_W'(g);
    end
  endfunction
endpackage

// File: rtl/bv_prior_table.sv
// Rule priority table: one write port, LANE parallel combinational reads of one group.
module bv_prior_table
  import bv_lookup_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [PRIOR_W-1:0]      wr_prior,
  input  logic [GRP_W-1:0]        rd_grp,
  output logic [LANE*PRIOR_W-1:0] rd_prior
);
  logic [PRIOR_W-1:0] tbl [RULE_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < RULE_NUM; r++) tbl[r] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_prior;
    end
  end

  // Reads see the pre-write contents, so a same-cycle write never leaks into the emitted group.
  always_comb begin
    rd_prior = '0;
    for (int l = 0; l < LANE; l++) begin
      rd_prior[l*PRIOR_W +: PRIOR_W] = tbl[{rd_grp, LANE_W'(l)}];
    end
  end
endmodule

// File: rtl/bv_cand_gen.sv
// Slices each matched-rule bit vector into LANE-wide candidate groups for the priority tree.
module bv_cand_gen
  import bv_lookup_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_bv_valid,
  input  logic [RULE_NUM-1:0]     in_bv,
  output logic                    in_bv_ready,
  input  logic                    cfg_wr_en,
  input  logic [ADDR_W-1:0]       cfg_wr_addr,
  input  logic [PRIOR_W-1:0]      cfg_wr_prior,
  output logic [LANE-1:0]         out_sel_valid,
  output logic [LANE*PRIOR_W-1:0] out_sel_prior,
  output logic [LANE*IDX_W-1:0]   out_sel_index,
  output logic                    out_grp_valid,
  output logic                    out_grp_first,
  output logic                    out_grp_last
);
  state_t                  state, state_nxt;
  logic [RULE_NUM-1:0]     bv_p0;
  logic [GRP_NUM-1:0]      pend_mask, acc_mask, grp_bit;
  logic                    first_pend, last_grp, accept, emit;
  logic [GRP_W-1:0]        grp;
  logic [LANE-1:0]         chunk [GRP_NUM];
  logic [LANE*PRIOR_W-1:0] tbl_prior;
  logic [LANE-1:0]         sel_valid_nxt;
  logic [LANE*IDX_W-1:0]   sel_index_nxt;

  bv_prior_table u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_wr_en),
    .wr_addr  (cfg_wr_addr),
    .wr_prior (cfg_wr_prior),
    .rd_grp   (grp),
    .rd_prior (tbl_prior)
  );

  assign grp         = lowest_grp(pend_mask);
  assign grp_bit     = GRP_NUM'(1) << grp;
  assign last_grp    = $onehot(pend_mask);
  assign emit        = (state == SCAN);
  assign in_bv_ready = (state == IDLE) || (emit && last_grp);
  assign accept      = in_bv_valid && in_bv_ready;

  // A total miss still issues one all-invalid group so the merge stage sees every lookup.
  always_comb begin
    acc_mask = '0;
    for (int g = 0; g < GRP_NUM; g++) acc_mask[g] = |in_bv[g*LANE +: LANE];
    if (acc_mask == '0) acc_mask = GRP_NUM'(1);
  end

  always_comb begin
    for (int g = 0; g < GRP_NUM; g++) chunk[g] = bv_p0[g*LANE +: LANE];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (!accept && last_grp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mask  <= '0;
      first_pend <= 1'b0;
    end else if (accept) begin
      pend_mask  <= acc_mask;
      first_pend <= 1'b1;
    end else if (emit) begin
      pend_mask  <= pend_mask & ~grp_bit;
      first_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) bv_p0 <= in_bv;
  end

  always_comb begin
    sel_valid_nxt = '0;
    sel_index_nxt = '0;
    if (emit) begin
      sel_valid_nxt = chunk[grp];
      for (int l = 0; l < LANE; l++) begin
        sel_index_nxt[l*IDX_W +: IDX_W] = IDX_W'({grp, LANE_W'(l)});
      end
    end
  end

  // Output stage: one group per cycle while scanning, all zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sel_valid <= '0;
      out_sel_prior <= '0;
      out_sel_index <= '0;
      out_grp_valid <= 1'b0;
      out_grp_first <= 1'b0;
      out_grp_last  <= 1'b0;
    end else begin
      out_sel_valid <= sel_valid_nxt;
      out_sel_prior <= emit ? tbl_prior : '0;
      out_sel_index <= sel_index_nxt;
      out_grp_valid <= emit;
      out_grp_first <= emit && first_pend;
      out_grp_last  <= emit && last_grp;
    end
  end
endmodule

// File: tb/tb_bv_cand_gen.sv
// Directed and randomized checks of bv_cand_gen against a queue-based group model.
module tb_bv_cand_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_bv_valid;
  logic [31:0] in_bv;
  logic        in_bv_ready;
  logic        cfg_wr_en;
  logic [4:0]  cfg_wr_addr;
  logic [7:0]  cfg_wr_prior;
  logic [7:0]  out_sel_valid;
  logic [63:0] out_sel_prior;
  logic [63:0] out_sel_index;
  logic        out_grp_valid, out_grp_first, out_grp_last;

  bv_cand_gen dut (
    .clk           (clk),
    .rst           (rst),
    .in_bv_valid   (in_bv_valid),
    .in_bv         (in_bv),
    .in_bv_ready   (in_bv_ready),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_prior  (cfg_wr_prior),
    .out_sel_valid (out_sel_valid),
    .out_sel_prior (out_sel_prior),
    .out_sel_index (out_sel_index),
    .out_grp_valid (out_grp_valid),
    .out_grp_first (out_grp_first),
    .out_grp_last  (out_grp_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] valid;
    int         grp;
    bit         first;
    bit         last;
  } grp_t;

  grp_t       q[$];
  logic [7:0] mtab [32];
  logic [7:0]  e_sv;
  logic [63:0] e_pr, e_ix;
  logic        e_gv, e_first, e_last;
  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected groups of one lookup: every non-empty chunk in ascending order, or chunk 0 on a miss.
  task automatic push_vec(input logic [31:0] bv);
    grp_t g;
    int   hits[$];
    for (int i = 0; i < 4; i++) if (bv[i*8 +: 8] != 8'h00) hits.push_back(i);
    if (hits.size() == 0) hits.push_back(0);
    foreach (hits[k]) begin
      g.grp   = hits[k];
      g.valid = bv[hits[k]*8 +: 8];
      g.first = (k == 0);
      g.last  = (k == hits.size() - 1);
      q.push_back(g);
    end
  endtask

  task automatic clear_exp();
    e_gv = 0; e_first = 0; e_last = 0; e_sv = '0; e_pr = '0; e_ix = '0;
  endtask

  task automatic cycle(input bit v, input logic [31:0] bv, input bit we,
                       input logic [4:0] wa, input logic [7:0] wp, input bit r);
    grp_t gi;
    bit   rdy;
    @(negedge clk);
    in_bv_valid = v; in_bv = bv; cfg_wr_en = we; cfg_wr_addr = wa; cfg_wr_prior = wp; rst = r;
    rdy = (q.size() <= 1);
    #1 chk("ready", 64'(in_bv_ready), 64'(rdy));
    if (r) begin
      q.delete();
      for (int i = 0; i < 32; i++) mtab[i] = '0;
      clear_exp();
    end else begin
      if (q.size() > 0) begin
        gi = q.pop_front();
        e_gv = 1; e_first = gi.first; e_last = gi.last; e_sv = gi.valid;
        for (int l = 0; l < 8; l++) begin
          e_pr[l*8 +: 8] = mtab[gi.grp*8 + l];
          e_ix[l*8 +: 8] = 8'(gi.grp*8 + l);
        end
      end else begin
        clear_exp();
      end
      if (v && rdy) push_vec(bv);
      if (we) mtab[wa] = wp;
    end
    @(posedge clk);
    #1;
    chk("grp_valid", 64'(out_grp_valid), 64'(e_gv));
    chk("grp_first", 64'(out_grp_first), 64'(e_first));
    chk("grp_last",  64'(out_grp_last),  64'(e_last));
    chk("sel_valid", 64'(out_sel_valid), 64'(e_sv));
    chk("sel_prior", out_sel_prior, e_pr);
    chk("sel_index", out_sel_index, e_ix);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    logic [31:0] rbv;
    rst = 1; in_bv_valid = 0; in_bv = '0; cfg_wr_en = 0; cfg_wr_addr = '0; cfg_wr_prior = '0;
    clear_exp();
    for (int i = 0; i < 32; i++) mtab[i] = '0;
    repeat (2) @(posedge clk);
    cycle(0, '0, 0, '0, '0, 1);
    chk("reset_ready", 64'(in_bv_ready), 64'd1);

    // Two hits in groups 0 and 1.
    for (int r = 0; r < 32; r++) cycle(0, '0, 1, 5'(r), 8'(r + 16), 0);
    cycle(1, 32'h0000_0101, 0, '0, '0, 0);
    idle(1);
    chk("t1_g0_prior", 64'(out_sel_prior[7:0]), 64'd16);
    chk("t1_g0_first", 64'(out_grp_first), 64'd1);
    idle(1);
    chk("t1_g1_prior", 64'(out_sel_prior[7:0]), 64'd24);
    chk("t1_g1_index", 64'(out_sel_index[7:0]), 64'd8);
    chk("t1_g1_last",  64'(out_grp_last), 64'd1);
    idle(1);

    // Total miss.
    cycle(1, 32'h0, 0, '0, '0, 0);
    idle(1);
    chk("t2_index", out_sel_index, 64'h0706_0504_0302_0100);
    chk("t2_firstlast", {62'd0, out_grp_first, out_grp_last}, 64'd3);
    idle(1);
    chk("t2_idle", 64'(out_grp_valid), 64'd0);

    // Back-to-back lookups, no bubble.
    cycle(1, 32'h8000_0000, 0, '0, '0, 0);
    cycle(1, 32'hFFFF_FFFF, 0, '0, '0, 0);
    chk("t3_g3_valid", 64'(out_sel_valid), 64'h80);
    for (int g = 0; g < 4; g++) begin
      idle(1);
      chk("t3_nogap", 64'(out_grp_valid), 64'd1);
    end
    idle(1);

    // Same-cycle write and emit of rule 24.
    cycle(1, 32'h0100_0000, 0, '0, '0, 0);
    cycle(0, '0, 1, 5'd24, 8'h55, 0);
    chk("t4_old_prior", 64'(out_sel_prior[7:0]), 64'h28);
    idle(1);
    cycle(1, 32'h0100_0000, 0, '0, '0, 0);
    idle(1);
    chk("t4_new_prior", 64'(out_sel_prior[7:0]), 64'h55);

    // Reset mid-scan.
    cycle(1, 32'hFFFF_FFFF, 0, '0, '0, 0);
    idle(2);
    cycle(0, '0, 0, '0, '0, 1);
    chk("t5_rst_out", {out_sel_prior[7:0], out_sel_valid, 7'd0, out_grp_valid}, 64'd0);
    cycle(1, 32'h0000_0100, 0, '0, '0, 0);
    idle(1);
    chk("t5_cleared", 64'(out_sel_prior[7:0]), 64'd0);
    idle(1);

    // Randomized traffic with sparse chunks, config writes and occasional resets.
    for (int n = 0; n < 400; n++) begin
      rbv = $urandom;
      for (int g = 0; g < 4; g++) if ($urandom_range(1, 0) == 0) rbv[g*8 +: 8] = 8'h00;
      cycle(($urandom_range(1, 0) == 1), rbv, ($urandom_range(9, 0) < 3),
            5'($urandom_range(31, 0)), 8'($urandom), ($urandom_range(49, 0) == 0));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/bv_cand_gen.md
Name: bv_cand_gen

Overview:
- Upstream feeder of the 8-way pipelined priority-select tree in the BV lookup datapath.
- Accepts one 32-bit matched rule bit vector per lookup and slices it into 8-lane candidate groups, one group per cycle.
- Each candidate lane carries valid, an 8-bit priority from an internal configurable rule-priority table, and an 8-bit rule index.
- Sideband first/last flags let the downstream merge stage combine per-group tree winners into one per-lookup result.

Parameters:
RULE_NUM, 32, rules per bit vector; must be a multiple of LANE.
LANE, 8, candidates per group; equals the tree width.
PRIOR_W, 8, priority width.
IDX_W, 8, rule index width.
GRP_NUM, RULE_NUM/LANE (4), derived local; groups per vector.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_bv_valid  in  1  bit vector offered.
in_bv  in  RULE_NUM  matched-rule bit vector; bit r = rule r hit.
in_bv_ready  out  1  block accepts in_bv this cycle.
cfg_wr_en  in  1  priority table write strobe.
cfg_wr_addr  in  5  rule number to write.
cfg_wr_prior  in  PRIOR_W  priority value.
out_sel_valid  out  LANE  per-lane candidate valid.
out_sel_prior  out  LANE*PRIOR_W  lane l at bits [8l+7:8l].
out_sel_index  out  LANE*IDX_W  lane l index = LANE*g + l.
out_grp_valid  out  1  group present on out_sel_* this cycle.
out_grp_first  out  1  first group of a lookup.
out_grp_last  out  1  last group of a lookup.

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs 0, pend_mask 0, state IDLE, all priority table entries 0. Reset asserted mid-lookup aborts it with no further groups; a new vector can be accepted the cycle after rst deasserts.
- Priority table: RULE_NUM x PRIOR_W registers, written on cfg_wr_en. On a same-cycle write and emit of the same rule, the emitted priority is the old value (read-before-write).
- States: IDLE and SCAN.
- in_bv_ready = (state==IDLE) or (state==SCAN and pend_mask has exactly one bit set). It is combinational from state only, with no dependence on in_bv_valid.
- Accept: on in_bv_valid && in_bv_ready, latch in_bv. pend_mask[g] = |in_bv[8g+7:8g]. If the result is all zero, force pend_mask = 4'b0001 so that a miss still yields one all-invalid group. Set first_pend = 1 and go to (or stay in) SCAN.
- SCAN, each cycle:
  - g = lowest set bit of pend_mask.
  - Register outputs for the next edge: out_sel_valid = bv chunk g; out_sel_prior lane l = table[8g+l] (invalid lanes also carry their table value); out_sel_index lane l = 8g+l.
  - out_grp_valid = 1, out_grp_first = first_pend, out_grp_last = (pend_mask has one bit set).
  - Clear pend_mask[g] and first_pend.
- If the last group is emitted and no new vector is accepted in that cycle, go to IDLE. When idle, out_grp_valid/first/last = 0 and the out_sel_* fields hold 0.
- Latency: vector accepted at edge T; first group is valid after edge T+1.
- Throughput: a lookup with n non-empty groups emits n consecutive groups. Back-to-back lookups produce no bubble, because the next vector is accepted while the previous lookup's last group is being issued.
- No backpressure: the downstream tree never stalls.
- Zero-chunk groups are skipped. Group order is ascending g, so index order is ascending.

Decomposition:
- Shared package bv_lookup_pkg: LANE, PRIOR_W, IDX_W, RULE_NUM, derived GRP_NUM, and the state enum {IDLE, SCAN}.
- One natural sub-module, bv_prior_table: the register-array priority table, with a write port and LANE parallel read ports addressed by group number.
- The group selector and FSM stay in the top level.

Test Plan:
1. Reset, then cfg write table[r] = r+16 for all r; in_bv = 0x0000_0101 -> two groups on consecutive cycles.
   - Group 0: sel_valid=0x01, index lane0=0, prior lane0=16, first=1, last=0.
   - Group 1: sel_valid=0x01, index lane0=8, prior lane0=24, first=0, last=1.
2. in_bv = 0 -> exactly one group with sel_valid=0x00, first=1, last=1, indices 0..7; returns to IDLE.
3. in_bv = 0x8000_0000, then 0xFFFF_FFFF held valid -> the second vector is accepted on the cycle its predecessor's single group issues. Groups then follow with no gap: g3 (valid 0x80, first=last=1), then g0..g3 (valid 0xFF, first on g0, last on g3).
4. In the cycle rule 24 is emitted, write cfg addr 24 = 0x55 -> the emitted prior is the old value. The next lookup hitting rule 24 shows 0x55.
5. Assert rst for one cycle while in_bv = 0xFFFF_FFFF is mid-scan at group 1 -> no further groups, all outputs 0, table cleared. The next vector is accepted one cycle after rst drops.
